// File: rtl/video_timing_gen_if.sv
// Timing-source strobe bundle between video_timing_gen and the stream output port.
// VTG_FRAME_CNT_EN adds the frame_cnt signal.
interface video_timing_gen_if;
   logic        enable;
   logic [15:0] hactive;
   logic [15:0] vactive;
   logic        out_vsync;
   logic        out_hsync;
   logic        out_de;
   logic        first_vld_byte;
   logic        line_last;
   logic        frame_done;
`ifdef VTG_FRAME_CNT_EN
   logic [15:0] frame_cnt;

   modport master (
      input  enable, hactive, vactive,
      output out_vsync, out_hsync, out_de, first_vld_byte, line_last, frame_done, frame_cnt
   );
   modport slave (
      output enable, hactive, vactive,
      input  out_vsync, out_hsync, out_de, first_vld_byte, line_last, frame_done, frame_cnt
   );
`else
   modport master (
      input  enable, hactive, vactive,
      output out_vsync, out_hsync, out_de, first_vld_byte, line_last, frame_done
   );
   modport slave (
      output enable, hactive, vactive,
      input  out_vsync, out_hsync, out_de, first_vld_byte, line_last, frame_done
   );
`endif
endinterface

// File: rtl/video_timing_gen.sv
// Free-running frame/line timing generator: sync, active-pixel and frame strobes.
// Optional VTG_FRAME_CNT_EN adds a 16-bit completed-frame counter.
module video_timing_gen #(
   parameter int HSYNC = 2,
   parameter int HBP   = 2,
   parameter int HFP   = 2,
   parameter int VSYNC = 1,
   parameter int VBP   = 1,
   parameter int VFP   = 1
) (
   input  logic               clock,
   input  logic               rst_n,
   video_timing_gen_if.master vif
);
   localparam logic [16:0] H_SYNC_W = 17'(HSYNC);
   localparam logic [16:0] H_LEAD   = 17'(HSYNC + HBP);
   localparam logic [16:0] H_TAIL   = 17'(HFP);
   localparam logic [16:0] V_SYNC_W = 17'(VSYNC);
   localparam logic [16:0] V_LEAD   = 17'(VSYNC + VBP);
   localparam logic [16:0] V_TAIL   = 17'(VFP);

   typedef enum logic {IDLE, RUN} state_t;
   state_t state, state_nxt;

   logic [15:0] hcnt, vcnt, hactive_l, vactive_l;
   logic [15:0] hact_sz, vact_sz;
   logic [16:0] hcnt_x, vcnt_x, h_end, v_end, htotal, vtotal;
   logic        frame_start, run, h_wrap, v_wrap;
   logic        hsync_p0, vsync_p0, de_p0, first_p0, last_p0, done_p0;
   logic        hsync_p1, vsync_p1, de_p1, first_p1, last_p1, done_p1;

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (!vif.enable)       state_nxt = IDLE;
      else if (state == IDLE) state_nxt = RUN;
   end

   // The sizes about to be latched already govern the frame-start clock itself.
   always_comb begin
      frame_start = (hcnt == 16'd0) && (vcnt == 16'd0);
      hact_sz     = frame_start ? vif.hactive : hactive_l;
      vact_sz     = frame_start ? vif.vactive : vactive_l;
      hcnt_x      = {1'b0, hcnt};
      vcnt_x      = {1'b0, vcnt};
      h_end       = H_LEAD + {1'b0, hact_sz};
      v_end       = V_LEAD + {1'b0, vact_sz};
      htotal      = h_end + H_TAIL;
      vtotal      = v_end + V_TAIL;
      h_wrap      = (hcnt_x == htotal - 17'd1);
      v_wrap      = (vcnt_x == vtotal - 17'd1);
      hsync_p0    = (hcnt_x < H_SYNC_W);
      vsync_p0    = (vcnt_x < V_SYNC_W);
      de_p0       = (hcnt_x >= H_LEAD) && (hcnt_x < h_end) &&
                    (vcnt_x >= V_LEAD) && (vcnt_x < v_end);
      first_p0    = de_p0 && (hcnt_x == H_LEAD) && (vcnt_x == V_LEAD);
      last_p0     = de_p0 && (hcnt_x == h_end - 17'd1);
      done_p0     = h_wrap && v_wrap;
      run         = vif.enable && (state == RUN);
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         hcnt      <= '0;
         vcnt      <= '0;
         hactive_l <= '0;
         vactive_l <= '0;
      end else begin
         if (vif.enable && frame_start) begin
            hactive_l <= vif.hactive;
            vactive_l <= vif.vactive;
         end
         if (!run) begin
            hcnt <= '0;
            vcnt <= '0;
         end else if (h_wrap) begin
            hcnt <= '0;
            vcnt <= v_wrap ? 16'd0 : vcnt + 16'd1;
         end else begin
            hcnt <= hcnt + 16'd1;
         end
      end
   end

   // Output register stage: decode of the current counters, zeroed whenever not running.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         hsync_p1 <= 1'b0;
         vsync_p1 <= 1'b0;
         de_p1    <= 1'b0;
         first_p1 <= 1'b0;
         last_p1  <= 1'b0;
         done_p1  <= 1'b0;
      end else begin
         hsync_p1 <= run && hsync_p0;
         vsync_p1 <= run && vsync_p0;
         de_p1    <= run && de_p0;
         first_p1 <= run && first_p0;
         last_p1  <= run && last_p0;
         done_p1  <= run && done_p0;
      end
   end

   assign vif.out_hsync      = hsync_p1;
   assign vif.out_vsync      = vsync_p1;
   assign vif.out_de         = de_p1;
   assign vif.first_vld_byte = first_p1;
   assign vif.line_last      = last_p1;
   assign vif.frame_done     = done_p1;

`ifdef VTG_FRAME_CNT_EN
   logic [15:0] frame_cnt_p1;

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n)                frame_cnt_p1 <= '0;
      else if (!vif.enable)      frame_cnt_p1 <= '0;
      else if (run && done_p0)   frame_cnt_p1 <= frame_cnt_p1 + 16'd1;
   end

   assign vif.frame_cnt = frame_cnt_p1;
`endif
endmodule

// File: tb/tb_video_timing_gen.sv
// Randomized bench for video_timing_gen against a frame-index reference model.
module tb_video_timing_gen;
   localparam int HSYNC = 2, HBP = 2, HFP = 2;
   localparam int VSYNC = 1, VBP = 1, VFP = 1;

   logic clock = 1'b0;
   logic rst_n = 1'b0;

   video_timing_gen_if vif();

   video_timing_gen #(
      .HSYNC(HSYNC), .HBP(HBP), .HFP(HFP),
      .VSYNC(VSYNC), .VBP(VBP), .VFP(VFP)
   ) dut (
      .clock(clock),
      .rst_n(rst_n),
      .vif  (vif)
   );

   always #5 clock = ~clock;

   int n_vec = 0;
   int n_bad = 0;

   // Model: position k is the clock index within the current frame.
   bit m_run;
   int m_k, m_ha, m_va, m_cnt;
   int e_vs, e_hs, e_de, e_fv, e_ll, e_fd;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_run = 1'b0; m_k = 0; m_ha = 0; m_va = 0; m_cnt = 0;
      e_vs = 0; e_hs = 0; e_de = 0; e_fv = 0; e_ll = 0; e_fd = 0;
   endtask

   task automatic model_step(input bit en, input int ha_in, input int va_in);
      int ht, vt, h, v;
      e_vs = 0; e_hs = 0; e_de = 0; e_fv = 0; e_ll = 0; e_fd = 0;
      if (!en) begin
         m_run = 1'b0; m_k = 0; m_cnt = 0;
      end else if (!m_run) begin
         m_run = 1'b1; m_k = 0; m_ha = ha_in; m_va = va_in;
      end else begin
         if (m_k == 0) begin
            m_ha = ha_in; m_va = va_in;
         end
         ht = HSYNC + HBP + m_ha + HFP;
         vt = VSYNC + VBP + m_va + VFP;
         h  = m_k % ht;
         v  = m_k / ht;
         e_hs = int'(h < HSYNC);
         e_vs = int'(v < VSYNC);
         e_de = int'(h >= HSYNC + HBP && h < HSYNC + HBP + m_ha &&
                     v >= VSYNC + VBP && v < VSYNC + VBP + m_va);
         e_fv = int'(e_de != 0 && h == HSYNC + HBP && v == VSYNC + VBP);
         e_ll = int'(e_de != 0 && h == HSYNC + HBP + m_ha - 1);
         if (m_k == ht * vt - 1) begin
            e_fd = 1; m_k = 0; m_cnt = (m_cnt + 1) % 65536;
         end else begin
            m_k++;
         end
      end
   endtask

   task automatic compare_all();
      check("vsync",      32'(vif.out_vsync),      32'(e_vs));
      check("hsync",      32'(vif.out_hsync),      32'(e_hs));
      check("de",         32'(vif.out_de),         32'(e_de));
      check("first_vld",  32'(vif.first_vld_byte), 32'(e_fv));
      check("line_last",  32'(vif.line_last),      32'(e_ll));
      check("frame_done", 32'(vif.frame_done),     32'(e_fd));
`ifdef VTG_FRAME_CNT_EN
      check("frame_cnt",  32'(vif.frame_cnt),      32'(m_cnt));
`endif
   endtask

   task automatic tick();
      @(posedge clock);
      model_step(vif.enable, int'(vif.hactive), int'(vif.vactive));
      #1;
      compare_all();
   endtask

   task automatic run_ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      int de_n, vs_n, hs_n, first_at, done_at, fv_n;
      vif.enable  = 1'b0;
      vif.hactive = 16'd4;
      vif.vactive = 16'd2;
      model_reset();
      #2;
      compare_all();
      @(negedge clock);
      @(negedge clock);
      rst_n = 1'b1;
      run_ticks(2);

      // Default frame: 10x5 clocks, 4x2 active.
      vif.enable = 1'b1;
      tick();
      de_n = 0; vs_n = 0; hs_n = 0; fv_n = 0; first_at = 0; done_at = 0;
      for (int n = 1; n <= 50; n++) begin
         tick();
         if (vif.out_de) de_n++;
         if (vif.out_vsync) vs_n++;
         if (vif.out_hsync) hs_n++;
         if (vif.first_vld_byte) begin
            fv_n++;
            if (first_at == 0) first_at = n;
         end
         if (vif.frame_done) done_at = n;
      end
      check("de_per_frame",    32'(de_n),     32'd8);
      check("vsync_clks",      32'(vs_n),     32'd10);
      check("hsync_clks",      32'(hs_n),     32'd10);
      check("first_vld_count", 32'(fv_n),     32'd1);
      check("first_de_clk",    32'(first_at), 32'd25);
      check("frame_done_clk",  32'(done_at),  32'd50);
`ifdef VTG_FRAME_CNT_EN
      check("frame_cnt_one",   32'(vif.frame_cnt), 32'd1);
`endif

      // Mid-frame size change only applies to the following frame.
      run_ticks(30);
      vif.hactive = 16'd6;
      run_ticks(150);

      // Single-pixel lines: first_vld_byte and line_last coincide.
      vif.hactive = 16'd1;
      vif.vactive = 16'd3;
      run_ticks(120);

      // Abort mid-line and restart.
      vif.hactive = 16'd4;
      vif.vactive = 16'd2;
      run_ticks(13);
      vif.enable = 1'b0;
      tick();
      vif.enable = 1'b1;
      run_ticks(60);

      // No active lines: sync keeps running, de stays low.
      vif.vactive = 16'd0;
      run_ticks(100);

      // Async reset mid-frame clears outputs immediately.
      rst_n = 1'b0;
      model_reset();
      #1;
      compare_all();
      @(negedge clock);
      rst_n = 1'b1;
      vif.vactive = 16'd2;
      run_ticks(40);

      // Randomized sizes and enable drops.
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 39) == 0) vif.enable = ~vif.enable;
         if ($urandom_range(0, 24) == 0) vif.hactive = 16'($urandom_range(0, 6));
         if ($urandom_range(0, 24) == 0) vif.vactive = 16'($urandom_range(0, 3));
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
